// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg : shared types and constants for the load/store controller
// Rev 1.0
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align : byte-lane strobes, store-data shift, load extract/extend
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  we_beat0,
  output logic [3:0]  we_beat1,
  output logic [31:0] wdata_beat0,
  output logic [31:0] wdata_beat1,
  output logic [31:0] ld_ext,
  output logic        misalign
);

  logic [3:0]  strb_base;
  logic [7:0]  strb_wide;
  logic [63:0] wdata_wide;
  logic [31:0] raw;

  always_comb begin
    strb_base = 4'b0000;
    case (funct3)
      F3_B, F3_BU: strb_base = STRB_B;
      F3_H, F3_HU: strb_base = STRB_H;
      F3_W:        strb_base = STRB_W;
      default:     strb_base = 4'b0000;
    endcase

    // The upper half of each wide shift is what spills into the second beat.
    strb_wide  = {4'b0000, strb_base} << off;
    wdata_wide = {32'd0, st_data} << {off, 3'b000};
    raw        = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});

    misalign = (strb_base == STRB_H && off == 2'd3) ||
               (strb_base == STRB_W && off != 2'd0);

    case (funct3)
      F3_B:    ld_ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ld_ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ld_ext = {24'd0, raw[7:0]};
      F3_HU:   ld_ext = {16'd0, raw[15:0]};
      default: ld_ext = raw;
    endcase
  end

  assign we_beat0    = strb_wide[3:0];
  assign we_beat1    = strb_wide[7:4];
  assign wdata_beat0 = wdata_wide[31:0];
  assign wdata_beat1 = wdata_wide[63:32];

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_ctrl : multi-cycle load/store controller towards a req/ack DMEM.
// `LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two beats. Rev 1.0
// ---------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        rd_we,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] st_data_q, st_data_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] timer_q, timer_d;
  logic        busy_q, busy_d, done_q, done_d, rd_we_q, rd_we_d;
  logic        misalign_err_q, misalign_err_d, bus_err_q, bus_err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_we_q, mem_we_d;

  // In IDLE the live inputs drive the aligner; afterwards the latched copies do.
  logic        idle, sel_store, sel_illegal, reject, split, ack, timed_out;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [31:0] sel_st, rdata_lo;
  logic [3:0]  we_beat0, we_beat1;
  logic [31:0] wdata_beat0, wdata_beat1, ld_ext;
  logic        misalign;

  assign idle        = (state_q == IDLE);
  assign sel_store   = idle ? is_store   : is_store_q;
  assign sel_f3      = idle ? funct3     : funct3_q;
  assign sel_off     = idle ? addr[1:0]  : off_q;
  assign sel_st      = idle ? st_data    : st_data_q;
  assign rdata_lo    = (state_q == BEAT1) ? rdata0_q : mem_rdata;
  assign sel_illegal = f3_illegal(sel_store, sel_f3);
  assign reject      = sel_illegal | (misalign & ~SPLIT_EN);
  assign split       = misalign & SPLIT_EN;
  assign ack         = mem_req_q & mem_ack;
  assign timed_out   = (TIMEOUT_CYCLES != 0) && (timer_q + 32'd1 == TIMEOUT_CYCLES);

  lsu_align u_align (
    .funct3      (sel_f3),
    .off         (sel_off),
    .st_data     (sel_st),
    .rdata_lo    (rdata_lo),
    .rdata_hi    (mem_rdata),
    .we_beat0    (we_beat0),
    .we_beat1    (we_beat1),
    .wdata_beat0 (wdata_beat0),
    .wdata_beat1 (wdata_beat1),
    .ld_ext      (ld_ext),
    .misalign    (misalign)
  );

  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    st_data_d      = st_data_q;
    rdata0_d       = rdata0_q;
    timer_d        = timer_q;
    busy_d         = busy_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_we_d       = mem_we_q;
    mem_wdata_d    = mem_wdata_q;
    done_d         = 1'b0;
    ld_data_d      = 32'd0;
    rd_we_d        = 1'b0;
    misalign_err_d = 1'b0;
    bus_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          st_data_d  = st_data;
          timer_d    = 32'd0;
          busy_d     = 1'b1;
          if (reject) begin
            state_d = RESP;
          end else begin
            state_d     = BEAT0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_we_d    = is_store ? we_beat0 : 4'b0000;
            mem_wdata_d = is_store ? wdata_beat0 : 32'd0;
          end
        end
      end

      BEAT0, BEAT1: begin
        if (ack) begin
          timer_d = 32'd0;
          if (state_q == BEAT0 && split) begin
            state_d     = BEAT1;
            rdata0_d    = mem_rdata;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_we_d    = is_store_q ? we_beat1 : 4'b0000;
            mem_wdata_d = is_store_q ? wdata_beat1 : 32'd0;
          end else begin
            state_d     = RESP;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            mem_req_d   = 1'b0;
            mem_addr_d  = 32'd0;
            mem_we_d    = 4'b0000;
            mem_wdata_d = 32'd0;
            ld_data_d   = is_store_q ? 32'd0 : ld_ext;
            rd_we_d     = ~is_store_q;
          end
        end else if (timed_out) begin
          state_d     = RESP;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          bus_err_d   = 1'b1;
          mem_req_d   = 1'b0;
          mem_addr_d  = 32'd0;
          mem_we_d    = 4'b0000;
          mem_wdata_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      RESP: begin
        // Rejected accesses arrive here without a done yet; emit it one cycle later.
        if (!done_q) begin
          done_d         = 1'b1;
          busy_d         = 1'b0;
          bus_err_d      = sel_illegal;
          misalign_err_d = ~SPLIT_EN & ~sel_illegal;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      st_data_q      <= 32'd0;
      rdata0_q       <= 32'd0;
      timer_q        <= 32'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ld_data_q      <= 32'd0;
      rd_we_q        <= 1'b0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_we_q       <= 4'b0000;
      mem_wdata_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      st_data_q      <= st_data_d;
      rdata0_q       <= rdata0_d;
      timer_q        <= timer_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      ld_data_q      <= ld_data_d;
      rd_we_q        <= rd_we_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ld_data      = ld_data_q;
  assign rd_we        = rd_we_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu_ctrl : randomized bench for lsu_ctrl against a byte-level memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int TO = 4;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        busy, done, rd_we, misalign_err, bus_err, mem_req, mem_ack;
  logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .st_data(st_data), .busy(busy), .done(done), .ld_data(ld_data),
    .rd_we(rd_we), .misalign_err(misalign_err), .bus_err(bus_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory; untouched bytes read a fixed address-derived pattern.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Memory responder: acks each beat after ack_delay waiting cycles.
  int          ack_delay, delay_left, req_cycles, beats, strb_bits;
  bit          stall, pend;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_we0, p_we;
  logic [31:0] beat_wdata0, p_addr, p_wdata;

  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      pend    = 1'b0;
    end else begin
      req_cycles++;
      if (pend) begin
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_we", 32'(mem_we), 32'(p_we));
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      if (!stall && delay_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_word(mem_addr);
        chk("beat_aligned", 32'(mem_addr[1:0]), 32'd0);
        for (int l = 0; l < 4; l++)
          if (mem_we[l]) begin
            mem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
            strb_bits++;
          end
        if (beats < 2) beat_addr[beats] = mem_addr;
        if (beats == 0) begin
          beat_we0    = mem_we;
          beat_wdata0 = mem_wdata;
        end
        beats++;
        delay_left = ack_delay;
        pend       = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (delay_left > 0) delay_left--;
        pend    = 1'b1;
        p_addr  = mem_addr;
        p_we    = mem_we;
        p_wdata = mem_wdata;
      end
    end
  end

  logic [31:0] last_ld;

  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int dly, input bit stl);
    int          sz, nb, exp_lat, cyc;
    bit          ill, mis, rej, seen;
    logic [31:0] exp_ld, got_st, exp_st, base;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    ill  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis  = (sz == 2 && a[1:0] == 2'd3) || (sz == 4 && a[1:0] != 2'd0);
    rej  = ill || (mis && !SPLIT);
    nb   = (rej || stl) ? 0 : (mis ? 2 : 1);
    base = {a[31:2], 2'b00};
    exp_ld = 32'd0;
    for (int i = 0; i < sz; i++) exp_ld[8*i +: 8] = rd_byte(a + 32'(i));
    if (f3 == 3'b000 && exp_ld[7])  exp_ld = exp_ld | 32'hFFFF_FF00;
    if (f3 == 3'b001 && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF_0000;
    exp_lat = rej ? 2 : (stl ? TO + 1 : nb * (dly + 1) + 1);

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; st_data = d;
    req_cycles = 0; beats = 0; strb_bits = 0;
    ack_delay = dly; delay_left = dly; stall = stl;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else chk("busy_during", 32'(busy), 32'd1);
      // Scribble the inputs (start included) to prove they were latched and ignored.
      start = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; st_data = $urandom;
    end
    if (!seen) begin
      chk("done_seen", 32'd0, 32'd1);
    end else begin
      last_ld = ld_data;
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("bus_err", 32'(bus_err), 32'(ill || (!rej && stl)));
      chk("misalign_err", 32'(misalign_err), 32'(!ill && mis && !SPLIT));
      chk("rd_we", 32'(rd_we), 32'(!st && !rej && !stl));
      chk("beats", 32'(beats), 32'(nb));
      if (!rej && stl) chk("timeout_reqs", 32'(req_cycles), 32'(TO));
      if (!rej && !stl) begin
        chk("req_cycles", 32'(req_cycles), 32'(nb * (dly + 1)));
        chk("beat0_addr", beat_addr[0], base);
        if (nb == 2) chk("beat1_addr", beat_addr[1], base + 32'd4);
        if (!st) chk("ld_data", ld_data, exp_ld);
        if (st) begin
          got_st = 32'd0;
          exp_st = 32'd0;
          for (int i = 0; i < sz; i++) begin
            got_st[8*i +: 8] = rd_byte(a + 32'(i));
            exp_st[8*i +: 8] = d[8*i +: 8];
          end
          chk("store_bytes", got_st, exp_st);
          chk("strobe_count", 32'(strb_bits), 32'(sz));
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    st_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    stall = 1'b0; ack_delay = 0; delay_left = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_errs", 32'({rd_we, misalign_err, bus_err}), 32'd0);
    reset = 1'b0;

    run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 1'b0);
    chk("sw_we", 32'(beat_we0), 32'hF);
    chk("sw_wdata", beat_wdata0, 32'hDEAD_BEEF);
    chk("sw_reqs", 32'(req_cycles), 32'd3);

    wr_word(32'h100, 32'h8012_3456);
    run_txn(1'b0, 3'b000, 32'h103, 32'd0, 0, 1'b0);
    chk("lb_value", last_ld, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h103, 32'd0, 1, 1'b0);
    chk("lbu_value", last_ld, 32'h0000_0080);

    run_txn(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 0, 1'b0);
    chk("sh_we", 32'(beat_we0), 32'hC);
    chk("sh_wdata", beat_wdata0, 32'hABCD_0000);

    wr_word(32'h100, 32'h4433_2211);
    wr_word(32'h104, 32'h8877_6655);
    run_txn(1'b0, 3'b010, 32'h101, 32'd0, 0, 1'b0);
    if (SPLIT) chk("lw_split", last_ld, 32'h5544_3322);

    run_txn(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 0, 1'b0);
    run_txn(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1234_5678, 1, 1'b0);

    // Reset while the first beat waits for an ack.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
    stall = 1'b1; ack_delay = 0; delay_left = 0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    run_txn(1'b0, 3'b010, 32'h200, 32'd0, 1, 1'b0);

    run_txn(1'b0, 3'b010, 32'h300, 32'd0, 0, 1'b1);
    run_txn(1'b1, 3'b000, 32'h301, 32'hA5, 0, 1'b1);
    run_txn(1'b0, 3'b011, 32'h300, 32'd0, 0, 1'b0);
    run_txn(1'b1, 3'b100, 32'h300, 32'd0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                       : (32'h1000 + 32'($urandom_range(0, 63)));
      run_txn(1'($urandom), 3'($urandom), ra, $urandom, $urandom_range(0, 2),
              $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
